// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (D).
// Define CPU_MEM_ARB_RR_EN for round-robin; default is D priority with IF anti-starvation.
module cpu_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    wait_q, wait_d;
    logic          any_req, arb_en, pick_if;

    logic          if_gnt_q, if_gnt_d;
    logic          d_gnt_q, d_gnt_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          sel_dport_q, sel_dport_d;
    logic          acc_we_q, acc_we_d;

`ifdef CPU_MEM_ARB_RR_EN
    logic          last_if_q, last_if_d;
`else
    logic [3:0]    starve_q, starve_d;
`endif

    // Arbitration happens only on the edge leaving IDLE or RESP.
    always_comb begin
        any_req = if_req | d_req;
        arb_en  = any_req && (state_q == S_IDLE || state_q == S_RESP);
`ifdef CPU_MEM_ARB_RR_EN
        pick_if   = if_req && (!d_req || !last_if_q);
        last_if_d = arb_en ? pick_if : last_if_q;
`else
        pick_if  = if_req && (!d_req || starve_q == 4'(STARVE_MAX));
        starve_d = starve_q;
        if (arb_en) begin
            if (pick_if) begin
                starve_d = '0;
            end else if (if_req) begin
                starve_d = starve_q + 4'd1;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (MEM_LAT == 1) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end
            end
            S_WAIT: begin
                if (wait_q == 3'(MEM_LAT - 2)) begin
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_RESP: begin
                state_d = any_req ? S_ACCESS : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sel_dport_d = sel_dport_q;
        acc_we_d    = acc_we_q;
        busy_d      = (state_d != S_IDLE);
        if (arb_en) begin
            mem_en_d    = 1'b1;
            if_gnt_d    = pick_if;
            d_gnt_d     = !pick_if;
            sel_dport_d = !pick_if;
            acc_we_d    = !pick_if && d_we;
            mem_we_d    = acc_we_d;
            mem_addr_d  = pick_if ? if_addr : d_addr;
            mem_wdata_d = pick_if ? '0 : d_wdata;
        end
        // Response uses the latched winner, not a new winner picked this edge.
        if (state_q == S_RESP) begin
            if (sel_dport_q) begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = acc_we_q ? '0 : mem_rdata;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = mem_rdata;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            sel_dport_q <= 1'b0;
            acc_we_q    <= 1'b0;
`ifdef CPU_MEM_ARB_RR_EN
            last_if_q   <= 1'b0;
`else
            starve_q    <= '0;
`endif
        end else begin
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            sel_dport_q <= sel_dport_d;
            acc_we_q    <= acc_we_d;
`ifdef CPU_MEM_ARB_RR_EN
            last_if_q   <= last_if_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: instance A at MEM_LAT=1, instance B at MEM_LAT=3.
// Honours CPU_MEM_ARB_RR_EN for the expected grant order.
module tb_cpu_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic Reset;

    logic          a_if_req, a_if_gnt, a_if_rvalid;
    logic [AW-1:0] a_if_addr;
    logic [DW-1:0] a_if_rdata;
    logic          a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic [AW-1:0] a_d_addr;
    logic [DW-1:0] a_d_wdata, a_d_rdata;
    logic          a_mem_en, a_mem_we, a_busy;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_wdata, a_mem_rdata;

    logic          b_if_req, b_if_gnt, b_if_rvalid;
    logic [AW-1:0] b_if_addr;
    logic [DW-1:0] b_if_rdata;
    logic          b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic [AW-1:0] b_d_addr;
    logic [DW-1:0] b_d_wdata, b_d_rdata;
    logic          b_mem_en, b_mem_we, b_busy;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata;

    cpu_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
        .CLK(CLK), .Reset(Reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    cpu_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
        .CLK(CLK), .Reset(Reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] pat(input logic [9:0] a);
        if (a == 10'h010) return 32'hDEADBEEF;
        return {16'hA5A5, 6'h00, a};
    endfunction

    // Memory models: contents restored to the pattern on reset.
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [31:0] pb0, pb1, pb2;

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= pat(10'(i));
            a_mem_rdata <= '0;
        end else if (a_mem_en) begin
            if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
            else a_mem_rdata <= mem_a[a_mem_addr];
        end
    end

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 1024; i++) mem_b[i] <= pat(10'(i));
            pb0 <= '0;
            pb1 <= '0;
            pb2 <= '0;
        end else begin
            if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
            pb0 <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : 32'hBAD0BAD0;
            pb1 <= pb0;
            pb2 <= pb1;
        end
    end
    assign b_mem_rdata = pb2;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    int   nrv, gi, nxt;
    logic [31:0] cap;
    logic got_if [10];
    logic exp_if;

    initial begin
        Reset = 1'b0;
        a_if_req = 0; a_if_addr = '0; a_d_req = 0; a_d_we = 0; a_d_addr = '0; a_d_wdata = '0;
        b_if_req = 0; b_if_addr = '0; b_d_req = 0; b_d_we = 0; b_d_addr = '0; b_d_wdata = '0;

        step();
        chk("rst_if_gnt", 64'(a_if_gnt), 64'd0);
        chk("rst_d_gnt", 64'(a_d_gnt), 64'd0);
        chk("rst_rvalid", 64'({a_if_rvalid, a_d_rvalid}), 64'd0);
        chk("rst_rdata", 64'({a_if_rdata, a_d_rdata}), 64'd0);
        chk("rst_mem", 64'({a_mem_en, a_mem_we, a_mem_addr}), 64'd0);
        chk("rst_wdata", 64'(a_mem_wdata), 64'd0);
        chk("rst_busy", 64'({a_busy, b_busy}), 64'd0);
        Reset = 1'b1;
        step();

        // Single IF read, MEM_LAT=1
        a_if_addr = 10'h010; a_if_req = 1;
        step();
        chk("if_gnt", 64'(a_if_gnt), 64'd1);
        chk("if_d_gnt", 64'(a_d_gnt), 64'd0);
        chk("if_mem_en", 64'(a_mem_en), 64'd1);
        chk("if_mem_we", 64'(a_mem_we), 64'd0);
        chk("if_mem_addr", 64'(a_mem_addr), 64'h010);
        chk("if_busy", 64'(a_busy), 64'd1);
        a_if_req = 0;
        step();
        chk("if_gnt_pulse", 64'(a_if_gnt), 64'd0);
        chk("if_mem_en_pulse", 64'(a_mem_en), 64'd0);
        chk("if_rvalid_early", 64'(a_if_rvalid), 64'd0);
        chk("if_busy_resp", 64'(a_busy), 64'd1);
        step();
        chk("if_rvalid", 64'(a_if_rvalid), 64'd1);
        chk("if_rdata", 64'(a_if_rdata), 64'hDEADBEEF);
        chk("if_d_rvalid", 64'(a_d_rvalid), 64'd0);
        chk("if_busy_idle", 64'(a_busy), 64'd0);
        step();
        chk("if_rvalid_pulse", 64'(a_if_rvalid), 64'd0);
        chk("if_rdata_hold", 64'(a_if_rdata), 64'hDEADBEEF);

        // Store to top address, then read it back
        a_d_we = 1; a_d_addr = 10'h3FF; a_d_wdata = 32'h12345678; a_d_req = 1;
        step();
        chk("st_d_gnt", 64'(a_d_gnt), 64'd1);
        chk("st_mem_en", 64'(a_mem_en), 64'd1);
        chk("st_mem_we", 64'(a_mem_we), 64'd1);
        chk("st_mem_addr", 64'(a_mem_addr), 64'h3FF);
        chk("st_mem_wdata", 64'(a_mem_wdata), 64'h12345678);
        a_d_req = 0;
        step();
        step();
        chk("st_d_rvalid", 64'(a_d_rvalid), 64'd1);
        chk("st_d_rdata", 64'(a_d_rdata), 64'd0);
        chk("st_if_rvalid", 64'(a_if_rvalid), 64'd0);
        a_d_we = 0; a_d_req = 1;
        step();
        chk("ld_d_gnt", 64'(a_d_gnt), 64'd1);
        chk("ld_mem_we", 64'(a_mem_we), 64'd0);
        a_d_req = 0;
        step();
        step();
        chk("ld_d_rvalid", 64'(a_d_rvalid), 64'd1);
        chk("ld_d_rdata", 64'(a_d_rdata), 64'h12345678);
        chk("ld_if_rdata_hold", 64'(a_if_rdata), 64'hDEADBEEF);
        step();

        // Reset during ACCESS of a D load
        a_d_we = 0; a_d_addr = 10'h020; a_d_req = 1;
        step();
        chk("rm_d_gnt", 64'(a_d_gnt), 64'd1);
        Reset = 1'b0;
        step();
        chk("rm_gnt", 64'({a_if_gnt, a_d_gnt}), 64'd0);
        chk("rm_mem_en", 64'(a_mem_en), 64'd0);
        chk("rm_busy", 64'(a_busy), 64'd0);
        chk("rm_rvalid", 64'({a_if_rvalid, a_d_rvalid}), 64'd0);
        chk("rm_rdata", 64'({a_if_rdata, a_d_rdata}), 64'd0);
        Reset = 1'b1;
        step();
        chk("rm_regnt", 64'(a_d_gnt), 64'd1);
        chk("rm_regnt_addr", 64'(a_mem_addr), 64'h020);
        a_d_req = 0;
        nrv = 0; cap = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (a_d_rvalid) begin
                nrv++;
                cap = a_d_rdata;
            end
        end
        chk("rm_rvalid_count", 64'(nrv), 64'd1);
        chk("rm_rdata", 64'(cap), 64'hA5A50020);

        // Both ports requesting continuously
        a_d_we = 0; a_d_addr = 10'h005; a_if_addr = 10'h006;
        a_d_req = 1; a_if_req = 1;
        gi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("arb_gnt_excl", 64'(a_if_gnt & a_d_gnt), 64'd0);
            chk("arb_rvalid_excl", 64'(a_if_rvalid & a_d_rvalid), 64'd0);
            if ((a_if_gnt || a_d_gnt) && gi < 10) begin
                got_if[gi] = a_if_gnt;
                gi++;
            end
        end
        a_d_req = 0; a_if_req = 0;
        chk("arb_gnt_count", 64'(gi), 64'd10);
        for (int i = 0; i < 10; i++) begin
`ifdef CPU_MEM_ARB_RR_EN
            exp_if = (i % 2 == 0);
`else
            exp_if = (i % 5 == 4);
`endif
            chk($sformatf("arb_order%0d", i), 64'(got_if[i]), 64'(exp_if));
        end
        step(); step(); step();

        // Back-to-back IF reads, MEM_LAT=3
        b_if_addr = 10'h100; b_if_req = 1; nxt = 1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("bb_mem_en%0d", i), 64'(b_mem_en), 64'(i % 4 == 1));
            chk($sformatf("bb_gnt%0d", i), 64'(b_if_gnt), 64'(i % 4 == 1));
            chk($sformatf("bb_rvalid%0d", i), 64'(b_if_rvalid), 64'(i % 4 == 1 && i >= 5));
            chk($sformatf("bb_busy%0d", i), 64'(b_busy), 64'd1);
            if (b_if_rvalid)
                chk($sformatf("bb_rdata%0d", i), 64'(b_if_rdata),
                    64'(pat(10'(10'h100 + (i - 5) / 4))));
            if (b_if_gnt) begin
                b_if_addr = 10'(10'h100 + nxt);
                nxt++;
            end
        end
        b_if_req = 0;
        step();
        chk("bb_last_rvalid", 64'(b_if_rvalid), 64'd1);
        chk("bb_last_rdata", 64'(b_if_rdata), 64'(pat(10'h103)));
        chk("bb_last_mem_en", 64'(b_mem_en), 64'd0);
        chk("bb_idle_busy", 64'(b_busy), 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
